// File: rtl/array_port_mem_if.sv
// Array port bundle: the kernel-side port, the host preload/dump port and the status lines.
// The master side is the kernel/host driver, and the slave side is array_port_mem.
interface array_port_mem_if #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 1
);
    logic              kernel_active;
    logic              k_wenable;
    logic [ADDR_W-1:0] k_addr;
    logic [DATA_W-1:0] k_wdata;
    logic [DATA_W-1:0] k_rdata;
    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_ack;
    logic [DATA_W-1:0] h_rdata;
    logic              clear_start;
    logic              ready;
    logic              err;

    modport master (
        output kernel_active, k_wenable, k_addr, k_wdata,
        output h_req, h_we, h_addr, h_wdata, clear_start,
        input  k_rdata, h_ack, h_rdata, ready, err
    );

    modport slave (
        input  kernel_active, k_wenable, k_addr, k_wdata,
        input  h_req, h_we, h_addr, h_wdata, clear_start,
        output k_rdata, h_ack, h_rdata, ready, err
    );
endinterface

// File: rtl/array_port_mem.sv
// Array storage that serves a running kernel, and a host port while the kernel is idle.
// A zero sweep runs after reset and whenever it is requested.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | sweeping zeros through mem[0..DEPTH-1]; no port is served
// ST_IDLE  | kernel is served when kernel_active=1, otherwise the host
module array_port_mem #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    array_port_mem_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              k_serve;
    logic              k_zero;
    logic              h_serve;
    logic              err_set;
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        k_serve   = 1'b0;
        k_zero    = 1'b0;
        h_serve   = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (&ptr_q) state_d = ST_IDLE;
                if (bus.kernel_active) begin
                    err_set = 1'b1;
                    k_zero  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.kernel_active) begin
                    k_serve = 1'b1;
                    if (bus.clear_start) err_set = 1'b1;
                    if (bus.k_wenable) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.k_addr;
                        mem_wdata = bus.k_wdata;
                    end
                end else if (bus.clear_start) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else if (bus.h_req) begin
                    h_serve = 1'b1;
                    if (bus.h_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.h_addr;
                        mem_wdata = bus.h_wdata;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // mem is deliberately left out of the reset branch: only the sweep zeroes it,
    // and no write commits on an edge where reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            bus.k_rdata <= '0;
            bus.h_rdata <= '0;
            bus.h_ack   <= 1'b0;
            bus.ready   <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            bus.ready <= (state_d == ST_IDLE);
            bus.h_ack <= h_serve;
            if (mem_we) mem[mem_waddr] <= mem_wdata;
            if (k_zero) bus.k_rdata <= '0;
            else if (k_serve) bus.k_rdata <= mem[bus.k_addr];
            if (h_serve && !bus.h_we) bus.h_rdata <= mem[bus.h_addr];
            if (err_set) bus.err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_array_port_mem.sv
// Directed bench for array_port_mem (ADDR_W=1, DATA_W=2): a vector table applied one edge
// per entry, plus hand-written sequences for reset, the start-up sweep and a reset mid-sweep.
`timescale 1ns/1ps
module tb_array_port_mem;
    localparam int AW = 1;
    localparam int DW = 2;

    typedef struct {
        logic          ka;
        logic          kwe;
        logic [AW-1:0] kaddr;
        logic [DW-1:0] kwd;
        logic          hreq;
        logic          hwe;
        logic [AW-1:0] haddr;
        logic [DW-1:0] hwd;
        logic          clr;
        logic [DW-1:0] ek;
        logic          eack;
        logic [DW-1:0] eh;
        logic          erdy;
        logic          eerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    array_port_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    array_port_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic ka, logic kwe, logic [AW-1:0] kaddr, logic [DW-1:0] kwd,
                                logic hreq, logic hwe, logic [AW-1:0] haddr, logic [DW-1:0] hwd,
                                logic clr, logic [DW-1:0] ek, logic eack, logic [DW-1:0] eh,
                                logic erdy, logic eerr);
        vec_t v;
        v.ka = ka;   v.kwe = kwe;   v.kaddr = kaddr; v.kwd = kwd;
        v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
        v.clr = clr; v.ek = ek; v.eack = eack; v.eh = eh; v.erdy = erdy; v.eerr = eerr;
        return v;
    endfunction

    // Output vector layout: {k_rdata, h_ack, h_rdata, ready, err}
    function automatic logic [6:0] outs();
        return {bus.k_rdata, bus.h_ack, bus.h_rdata, bus.ready, bus.err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.kernel_active = v.ka;
        bus.k_wenable     = v.kwe;
        bus.k_addr        = v.kaddr;
        bus.k_wdata       = v.kwd;
        bus.h_req         = v.hreq;
        bus.h_we          = v.hwe;
        bus.h_addr        = v.haddr;
        bus.h_wdata       = v.hwd;
        bus.clear_start   = v.clr;
    endtask

    task automatic drive_idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Counts posedges after reset release until ready rises, bounded.
    task automatic count_to_ready(input string name);
        int n;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ready === 1'b1) break;
        end
        check(name, n, 2);
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        // ka kwe ka kwd | hreq hwe ha hwd | clr || k_rdata ack h_rdata ready err
        vecs.push_back(mk(0,0,0,0, 1,0,0,0, 0,  0,1,0,1,0)); //  0 host read a0
        vecs.push_back(mk(0,0,0,0, 1,0,1,0, 0,  0,1,0,1,0)); //  1 host read a1
        vecs.push_back(mk(0,0,0,0, 1,1,1,3, 0,  0,1,0,1,0)); //  2 host write a1=3
        vecs.push_back(mk(0,0,0,0, 1,0,1,0, 0,  0,1,3,1,0)); //  3 host read a1
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,  0,0,3,1,0)); //  4 ack drops
        vecs.push_back(mk(1,0,1,0, 1,0,1,0, 0,  3,0,3,1,0)); //  5 kernel read, host blocked
        vecs.push_back(mk(1,0,1,0, 1,0,1,0, 0,  3,0,3,1,0)); //  6 still blocked
        vecs.push_back(mk(0,0,1,0, 1,0,1,0, 0,  3,1,3,1,0)); //  7 host served after release
        vecs.push_back(mk(1,1,1,1, 0,0,0,0, 0,  3,0,3,1,0)); //  8 kernel write: old data
        vecs.push_back(mk(1,0,1,0, 0,0,0,0, 0,  1,0,3,1,0)); //  9 new data
        vecs.push_back(mk(1,0,0,0, 0,0,0,0, 0,  0,0,3,1,0)); // 10 kernel read a0
        vecs.push_back(mk(1,0,1,0, 0,0,0,0, 1,  1,0,3,1,1)); // 11 clear with kernel -> err
        vecs.push_back(mk(0,1,0,2, 1,0,1,0, 0,  1,1,1,1,1)); // 12 idle kernel write ignored
        vecs.push_back(mk(0,0,0,0, 1,0,0,0, 0,  1,1,0,1,1)); // 13 a0 untouched
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,  1,0,0,0,1)); // 14 clear accepted
        vecs.push_back(mk(1,1,1,3, 0,0,0,0, 0,  0,0,0,0,1)); // 15 kernel during sweep
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,  0,0,0,1,1)); // 16 sweep done
        vecs.push_back(mk(0,0,0,0, 1,0,1,0, 0,  0,1,0,1,1)); // 17 a1 cleared
        vecs.push_back(mk(0,0,0,0, 1,0,0,0, 0,  0,1,0,1,1)); // 18 a0 cleared
        vecs.push_back(mk(0,0,0,0, 1,1,1,2, 0,  0,1,0,1,1)); // 19 host write a1=2
        vecs.push_back(mk(0,0,0,0, 1,0,1,0, 0,  0,1,2,1,1)); // 20 host read a1
        vecs.push_back(mk(1,0,1,0, 0,0,0,0, 0,  2,0,2,1,1)); // 21 kernel read a1

        drive_idle();
        #1;
        check("reset_outputs", outs(), 7'b0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", outs(), 7'b0);

        @(negedge clk);
        rst = 1'b0;
        count_to_ready("startup_sweep_edges");

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].ek, vecs[i].eack, vecs[i].eh, vecs[i].erdy, vecs[i].eerr});
        end

        // Reset asserted between edges, one edge into a requested sweep
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #2;
        check("pre_reset_mid_sweep", outs(), {2'd2, 1'b0, 2'd2, 1'b0, 1'b1});
        rst = 1'b1;
        #1;
        check("async_reset_immediate", outs(), 7'b0);
        @(negedge clk);
        rst = 1'b0;
        count_to_ready("restart_sweep_edges");

        drive(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        check("post_reset_read_a1", outs(), {2'd0, 1'b1, 2'd0, 1'b1, 1'b0});
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        check("post_reset_ack_drop", outs(), {2'd0, 1'b0, 2'd0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
